// File: rtl/bitty_pkg.sv
// Shared constants and types for the parametrised bitty core.
// Instruction format codes, ALU opcodes, field positions and FSM state.
package bitty_pkg;

    localparam logic [1:0] FMT_R   = 2'b00;
    localparam logic [1:0] FMT_I   = 2'b01;
    localparam logic [1:0] FMT_ILL = 2'b10;
    localparam logic [1:0] FMT_NOP = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SHL = 3'd5;
    localparam logic [2:0] ALU_SHR = 3'd6;
    localparam logic [2:0] ALU_CMP = 3'd7;

    localparam int RX_LO  = 13;
    localparam int RY_LO  = 10;
    localparam int IMM_LO = 5;
    localparam int OP_LO  = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH_A,
        S_EXEC,
        S_WB
    } state_e;

    // R- and I-type are the only formats that touch the datapath
    function automatic logic is_alu(input logic [1:0] fmt);
        return !fmt[1];
    endfunction

endpackage

// File: rtl/bitty_core_p_if.sv
// Instruction valid/ready handshake between source and core.
interface bitty_core_p_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/bitty_alu_p.sv
// Combinational ALU: result, carry/borrow and zero.
module bitty_alu_p
    import bitty_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_res,
    output logic              o_carry,
    output logic              o_zero
);
    localparam int SHW = $clog2(DATA_W);

    logic [DATA_W:0]  w_sum;
    logic [SHW-1:0]   w_sh;

    always_comb begin
        w_sum   = {1'b0, i_a} + {1'b0, i_b};
        w_sh    = i_b[SHW-1:0];
        o_res   = '0;
        o_carry = 1'b0;
        unique case (i_op)
            ALU_ADD: begin
                o_res   = w_sum[DATA_W-1:0];
                o_carry = w_sum[DATA_W];
            end
            ALU_SUB: begin
                o_res   = i_a - i_b;
                o_carry = (i_a < i_b);
            end
            ALU_AND: o_res = i_a & i_b;
            ALU_OR:  o_res = i_a | i_b;
            ALU_XOR: o_res = i_a ^ i_b;
            ALU_SHL: o_res = i_a << w_sh;
            ALU_SHR: o_res = i_a >> w_sh;
            ALU_CMP: begin
                if (i_a > i_b)      o_res = DATA_W'(1);
                else if (i_a < i_b) o_res = DATA_W'(2);
            end
        endcase
        o_zero = (o_res == '0);
    end
endmodule

// File: rtl/bitty_core_p.sv
// Parametrised bitty core: register file, S/C/IR latches and serial FSM.
// One instruction every four cycles; run=0 freezes everything.
module bitty_core_p
    import bitty_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    bitty_core_p_if.slave     bus,
    output logic [DATA_W-1:0] d_out,
    output logic              done,
    output logic              err,
    output logic              flag_z,
    output logic              flag_c
);
    state_e            r_state, w_next;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_s, r_c;
    logic [DATA_W-1:0] r_rf [8];
    logic              r_done, r_err, r_z, r_cy;

    logic              w_ready, w_accept;
    logic [1:0]        w_fmt;
    logic [2:0]        w_rx, w_ry, w_op;
    logic [7:0]        w_imm;
    logic [DATA_W-1:0] w_b, w_res;
    logic              w_carry, w_zero, w_wr_ok;

    assign w_fmt   = r_ir[1:0];
    assign w_rx    = r_ir[RX_LO +: 3];
    assign w_ry    = r_ir[RY_LO +: 3];
    assign w_op    = r_ir[OP_LO +: 3];
    assign w_imm   = r_ir[IMM_LO +: 8];
    assign w_b     = (w_fmt == FMT_R) ? r_rf[w_ry] : DATA_W'(w_imm);
    // Unimplemented registers are never written, so they read as zero
    assign w_wr_ok = is_alu(w_fmt) && (int'(w_rx) < NREGS);

    bitty_alu_p #(.DATA_W(DATA_W)) u_alu (
        .i_op    (w_op),
        .i_a     (r_s),
        .i_b     (w_b),
        .o_res   (w_res),
        .o_carry (w_carry),
        .o_zero  (w_zero)
    );

    always_comb begin
        w_next   = r_state;
        w_ready  = 1'b0;
        w_accept = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready  = run & reset;
                w_accept = w_ready & bus.instr_valid;
                if (w_accept) w_next = S_FETCH_A;
            end
            S_FETCH_A: if (run) w_next = S_EXEC;
            S_EXEC:    if (run) w_next = S_WB;
            S_WB:      if (run) w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ir   <= '0;
            r_s    <= '0;
            r_c    <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_z    <= 1'b0;
            r_cy   <= 1'b0;
            for (int k = 0; k < 8; k++) r_rf[k] <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (run) begin
                unique case (r_state)
                    S_IDLE: if (w_accept) r_ir <= bus.instr;
                    S_FETCH_A: r_s <= r_rf[w_rx];
                    S_EXEC: if (is_alu(w_fmt)) begin
                        r_c  <= w_res;
                        r_z  <= w_zero;
                        r_cy <= w_carry;
                    end
                    S_WB: begin
                        if (w_wr_ok) r_rf[w_rx] <= r_c;
                        r_done <= 1'b1;
                        r_err  <= (w_fmt == FMT_ILL);
                    end
                endcase
            end
        end
    end

    assign bus.instr_ready = w_ready;
    assign d_out  = r_c;
    assign done   = r_done;
    assign err    = r_err;
    assign flag_z = r_z;
    assign flag_c = r_cy;
endmodule

// File: tb/tb_bitty_core_p.sv
// Scoreboard bench: a 16-bit/8-reg core and an 8-bit/4-reg core.
module tb_bitty_core_p;
    import bitty_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic run16 = 1'b1;
    logic run8  = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bitty_core_p_if if16 ();
    bitty_core_p_if if8 ();

    logic [15:0] d16;
    logic [7:0]  d8;
    logic done16, err16, z16, c16;
    logic done8, err8, z8, c8;

    bitty_core_p #(.DATA_W(16), .NREGS(8)) u16 (
        .clk(clk), .reset(rst_n), .run(run16), .bus(if16),
        .d_out(d16), .done(done16), .err(err16),
        .flag_z(z16), .flag_c(c16)
    );

    bitty_core_p #(.DATA_W(8), .NREGS(4)) u8 (
        .clk(clk), .reset(rst_n), .run(run8), .bus(if8),
        .d_out(d8), .done(done8), .err(err8),
        .flag_z(z8), .flag_c(c8)
    );

    typedef struct {
        logic [31:0] d;
        bit          z;
        bit          c;
        bit          e;
        int          cyc;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [15:0] ii(int rx, int imm, logic [2:0] op);
        return {3'(rx), 8'(imm), op, FMT_I};
    endfunction

    function automatic logic [15:0] rr(int rx, int ry, logic [2:0] op);
        return {3'(rx), 3'(ry), 5'b0, op, FMT_R};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done16) begin
            if (q16.size() == 0) fail("u16 unexpected done");
            else begin
                e = q16.pop_front();
                chk("u16 d_out", {16'b0, d16}, e.d);
                chk("u16 flag_z", {31'b0, z16}, {31'b0, e.z});
                chk("u16 flag_c", {31'b0, c16}, {31'b0, e.c});
                chk("u16 err", {31'b0, err16}, {31'b0, e.e});
                chk("u16 done cycle", cyc, e.cyc);
            end
        end else if (err16 === 1'b1) fail("u16 err without done");
        if (rst_n === 1'b1 && done8) begin
            if (q8.size() == 0) fail("u8 unexpected done");
            else begin
                e = q8.pop_front();
                chk("u8 d_out", {24'b0, d8}, e.d);
                chk("u8 flag_z", {31'b0, z8}, {31'b0, e.z});
                chk("u8 flag_c", {31'b0, c8}, {31'b0, e.c});
                chk("u8 err", {31'b0, err8}, {31'b0, e.e});
                chk("u8 done cycle", cyc, e.cyc);
            end
        end else if (err8 === 1'b1) fail("u8 err without done");
    end

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic issue(input bit w8, input logic [15:0] ins,
                         input logic [31:0] d, input bit z, input bit c,
                         input bit e, input int stall, output int acc);
        int   t;
        exp_t x;
        t = 0;
        if (w8) begin if8.instr = ins; if8.instr_valid = 1'b1; end
        else    begin if16.instr = ins; if16.instr_valid = 1'b1; end
        while (!(w8 ? if8.instr_ready : if16.instr_ready) && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) begin
            fail(w8 ? "u8 accept timeout" : "u16 accept timeout");
            acc = -1;
        end else begin
            acc   = cyc + 1;
            x.d   = d;
            x.z   = z;
            x.c   = c;
            x.e   = e;
            x.cyc = acc + 3 + stall;
            if (w8) q8.push_back(x);
            else    q16.push_back(x);
            @(posedge clk);
        end
        #1;
        if (w8) if8.instr_valid = 1'b0;
        else    if16.instr_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int a1, a2, t;
        if16.instr = '0;
        if16.instr_valid = 1'b0;
        if8.instr = '0;
        if8.instr_valid = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset d_out", {16'b0, d16}, 32'h0);
        chk("reset flags", {30'b0, z16, c16}, 32'h0);
        chk("reset done/err", {30'b0, done16, err16}, 32'h0);
        chk("reset ready", {31'b0, if16.instr_ready}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(0, ii(1, 1, ALU_SUB), 32'hFFFF, 0, 1, 0, 0, a1);
        issue(0, ii(2, 1, ALU_ADD), 32'h0001, 0, 0, 0, 0, a1);
        issue(0, rr(1, 2, ALU_ADD), 32'h0000, 1, 1, 0, 0, a1);
        issue(0, ii(0, 8'hAB, ALU_ADD), 32'h00AB, 0, 0, 0, 0, a1);
        issue(0, ii(0, 8'hAC, ALU_SUB), 32'hFFFF, 0, 1, 0, 0, a2);
        chk("back-to-back accept spacing", a2 - a1, 4);

        issue(0, rr(0, 2, ALU_AND), 32'h0001, 0, 0, 0, 5, a1);
        run16 = 1'b0;
        repeat (5) @(negedge clk);
        run16 = 1'b1;

        issue(0, 16'hFFFE, 32'h0001, 0, 0, 1, 0, a1);
        issue(0, 16'hFFFF, 32'h0001, 0, 0, 0, 0, a1);
        issue(0, ii(0, 0, ALU_OR), 32'h0001, 0, 0, 0, 0, a1);
        issue(0, ii(7, 8'h0F, ALU_ADD), 32'h000F, 0, 0, 0, 0, a1);

        issue(0, ii(3, 8'h55, ALU_XOR), 32'h0055, 0, 0, 0, 0, a1);
        @(negedge clk);
        rst_n = 1'b0;
        void'(q16.pop_back());
        #1;
        chk("mid reset d_out", {16'b0, d16}, 32'h0);
        chk("mid reset done/err", {30'b0, done16, err16}, 32'h0);
        chk("mid reset flags", {30'b0, z16, c16}, 32'h0);
        chk("mid reset ready", {31'b0, if16.instr_ready}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        issue(0, ii(3, 7, ALU_ADD), 32'h0007, 0, 0, 0, 0, a1);
        issue(0, rr(0, 3, ALU_ADD), 32'h0007, 0, 0, 0, 0, a1);
        issue(0, ii(7, 8'h01, ALU_ADD), 32'h0001, 0, 0, 0, 0, a1);

        issue(1, ii(6, 5, ALU_ADD), 32'h05, 0, 0, 0, 0, a1);
        issue(1, ii(6, 0, ALU_ADD), 32'h00, 1, 0, 0, 0, a1);
        issue(1, ii(1, 8'h81, ALU_ADD), 32'h81, 0, 0, 0, 0, a1);
        issue(1, ii(1, 1, ALU_SHL), 32'h02, 0, 0, 0, 0, a1);
        issue(1, ii(2, 3, ALU_ADD), 32'h03, 0, 0, 0, 0, a1);
        issue(1, ii(3, 5, ALU_ADD), 32'h05, 0, 0, 0, 0, a1);
        issue(1, rr(2, 3, ALU_CMP), 32'h02, 0, 0, 0, 0, a1);
        issue(1, rr(3, 2, ALU_CMP), 32'h01, 0, 0, 0, 0, a1);
        issue(1, ii(1, 8'hFF, ALU_ADD), 32'h01, 0, 1, 0, 0, a1);
        issue(1, ii(2, 2, ALU_SHR), 32'h00, 1, 0, 0, 0, a1);

        t = 0;
        while ((q16.size() != 0 || q8.size() != 0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) fail("drain timeout: expected done never seen");
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
